// File: rtl/div_seq_ctrl_if.sv
// Bundle of handshake, step-stage and result signals for the sequential
// 8-bit restoring divider controller.
interface div_seq_ctrl_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [6:0] step_a;
  logic [7:0] step_b;
  logic       step_c;
  logic       step_s;
  logic [7:0] step_p;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  // The controller itself: takes requests and step results, drives the rest.
  modport slave (
    input  start, dividend, divisor, step_s, step_p,
    output step_a, step_b, step_c, quotient, remainder, busy, done, div_zero
  );

  // The environment: requester plus the external single-step stage.
  modport master (
    output start, dividend, divisor, step_s, step_p,
    input  step_a, step_b, step_c, quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequential controller for an 8-bit by 8-bit restoring divider. An external
// single-step stage computes one quotient bit per cycle; this block feeds it
// the partial remainder, divisor and next dividend bit, and collects results.
module div_seq_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  div_seq_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT      r_state;
  stateT      w_nextState;
  logic       w_busy;
  logic       w_done;

  logic [7:0] r_bReg;
  logic [7:0] r_dvdShift;
  logic [7:0] r_rem;
  logic [7:0] r_qShift;
  logic [2:0] r_cnt;
  logic [7:0] r_quotient;
  logic [7:0] r_remainder;
  logic       r_divZero;

  // State register; reset returns to IDLE and aborts any division in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and status decode; a zero divisor bypasses RUN entirely.
  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextState = (bus.divisor != 8'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == 3'd0) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, one restoring step per RUN cycle, result load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bReg      <= 8'd0;
      r_dvdShift  <= 8'd0;
      r_rem       <= 8'd0;
      r_qShift    <= 8'd0;
      r_cnt       <= 3'd0;
      r_quotient  <= 8'd0;
      r_remainder <= 8'd0;
      r_divZero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != 8'd0) begin
              r_bReg     <= bus.divisor;
              r_dvdShift <= bus.dividend;
              r_rem      <= 8'd0;
              r_qShift   <= 8'd0;
              r_cnt      <= 3'd7;
            end else begin
              r_quotient  <= 8'hFF;
              r_remainder <= bus.dividend;
              r_divZero   <= 1'b1;
            end
          end
        end
        RUN: begin
          r_rem      <= bus.step_p;
          r_qShift   <= {r_qShift[6:0], bus.step_s};
          r_dvdShift <= {r_dvdShift[6:0], 1'b0};
          r_cnt      <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_quotient  <= {r_qShift[6:0], bus.step_s};
            r_remainder <= bus.step_p;
            r_divZero   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // rem[7] is intentionally dropped: before each shift the partial remainder
  // of an 8-bit division is always below 128.
  assign bus.step_a    = r_rem[6:0];
  assign bus.step_b    = r_bReg;
  assign bus.step_c    = r_dvdShift[7];
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.div_zero  = r_divZero;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed testbench for div_seq_ctrl with a behavioural restoring step stage.
module tb_div_seq_ctrl;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;

  div_seq_ctrl_if bus ();

  div_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External single-step stage: shift in the next bit, subtract if it fits.
  logic [7:0] stepT;
  always_comb begin
    stepT = {bus.step_a, bus.step_c};
    if (stepT >= bus.step_b) begin
      bus.step_s = 1'b1;
      bus.step_p = stepT - bus.step_b;
    end else begin
      bus.step_s = 1'b0;
      bus.step_p = stepT;
    end
  end

  // One comparison point: counts it and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue one division from IDLE and check latency, busy span and results.
  task automatic applyStimulus(input string tag, input logic [7:0] dvd,
                               input logic [7:0] dsr, input logic [7:0] expQ,
                               input logic [7:0] expR, input logic expZ,
                               input int expLat, input int expBusy,
                               input bit disturb);
    int lat;
    int busyN;
    lat   = 0;
    busyN = 0;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dsr;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (disturb && k == 3) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd255;
        bus.divisor  = 8'd1;
      end
      if (bus.busy) busyN++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, ".latency"}, lat, expLat);
    checkOutput({tag, ".busyCycles"}, busyN, expBusy);
    checkOutput({tag, ".quotient"}, bus.quotient, expQ);
    checkOutput({tag, ".remainder"}, bus.remainder, expR);
    checkOutput({tag, ".divZero"}, bus.div_zero, expZ);
    @(negedge clk);
    checkOutput({tag, ".donePulseEnd"}, bus.done, 0);
    checkOutput({tag, ".quotientHeld"}, bus.quotient, expQ);
  endtask

  // Directed test sequence.
  initial begin
    int doneSeen;
    int firstDone;
    int secondDone;
    assertCount  = 0;
    failCount    = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;

    repeat (2) @(negedge clk);
    checkOutput("reset.busy", bus.busy, 0);
    checkOutput("reset.done", bus.done, 0);
    checkOutput("reset.quotient", bus.quotient, 0);
    checkOutput("reset.remainder", bus.remainder, 0);
    checkOutput("reset.divZero", bus.div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("d200_7",   8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9, 8, 1'b0);
    applyStimulus("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 8, 1'b0);
    applyStimulus("d13_200",  8'd13,  8'd200, 8'd0,   8'd13,  1'b0, 9, 8, 1'b0);
    applyStimulus("d255_128", 8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 9, 8, 1'b0);
    applyStimulus("d0_5",     8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9, 8, 1'b0);
    applyStimulus("d77_0",    8'd77,  8'd0,   8'hFF,  8'd77,  1'b1, 1, 0, 1'b0);
    applyStimulus("d100_9",   8'd100, 8'd9,   8'd11,  8'd1,   1'b0, 9, 8, 1'b1);

    // Abort a division with reset on its fourth RUN cycle.
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd9;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort.busy", bus.busy, 0);
    checkOutput("abort.done", bus.done, 0);
    checkOutput("abort.quotient", bus.quotient, 0);
    checkOutput("abort.remainder", bus.remainder, 0);
    checkOutput("abort.divZero", bus.div_zero, 0);
    checkOutput("abort.stepA", bus.step_a, 0);
    checkOutput("abort.stepB", bus.step_b, 0);
    checkOutput("abort.stepC", bus.step_c, 0);
    rst_n    = 1'b1;
    doneSeen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("abort.noDone", doneSeen, 0);
    applyStimulus("d50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9, 8, 1'b0);

    // Start held high: divisions run back to back.
    firstDone    = 0;
    secondDone   = 0;
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (firstDone == 0) begin
          firstDone = k;
        end else begin
          secondDone = k;
          checkOutput("b2b.quotient", bus.quotient, 28);
          bus.start = 1'b0;
          break;
        end
      end
    end
    checkOutput("b2b.firstDone", firstDone, 9);
    checkOutput("b2b.spacing", secondDone - firstDone, 10);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b2b.idleBusy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
